// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between predictor, branch resolve queue and branch execute.
// The slave side is the queue; the master side is whoever drives the predictions and outcomes.
interface branch_resolve_queue_if #(
  parameter int unsigned ID_W = 1
);
  logic            push_valid;
  logic            push_ready;
  logic            push_taken;
  logic [ID_W-1:0] push_branch;
  logic            push_src;
  logic            res_valid;
  logic            res_ready;
  logic            res_taken;
  logic [ID_W-1:0] res_branch;
  logic            update_valid;
  logic            update_taken;
  logic [ID_W-1:0] update_branch;
  logic            flush;
  logic [ID_W-1:0] flush_branch;

  modport slave (
    input  push_valid, push_taken, push_branch, push_src,
    input  res_valid, res_taken, res_branch,
    output push_ready, res_ready,
    output update_valid, update_taken, update_branch, flush, flush_branch
  );

  modport master (
    output push_valid, push_taken, push_branch, push_src,
    output res_valid, res_taken, res_branch,
    input  push_ready, res_ready,
    input  update_valid, update_taken, update_branch, flush, flush_branch
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued branch predictions awaiting resolution; trains the predictor,
// raises a one-cycle flush on a mispredict and keeps per-source mispredict statistics.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  branch_resolve_queue_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [CNT_W-1:0]             o_resolved_cnt,
  output logic [CNT_W-1:0]             o_mispredict_cnt,
  output logic [CNT_W-1:0]             o_mispredict_global_cnt,
  output logic                         o_id_error
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            taken;
    logic [ID_W-1:0] branch;
    logic            src;
  } entry_t;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  entry_t           r_mem [DEPTH];
  state_e           r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_update_valid;
  logic             r_update_taken;
  logic [ID_W-1:0]  r_update_branch;
  logic             r_flush;
  logic [ID_W-1:0]  r_flush_branch;
  logic [CNT_W-1:0] r_resolved_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;
  logic [CNT_W-1:0] r_mispredict_global_cnt;
  logic             r_id_error;

  logic   w_full;
  logic   w_empty;
  logic   w_push_ready;
  logic   w_res_ready;
  logic   w_push_fire;
  logic   w_res_fire;
  logic   w_mispredict;
  entry_t w_head;

  always_comb begin
    w_full       = (r_count == OCC_W'(DEPTH));
    w_empty      = (r_count == '0);
    w_push_ready = !w_full && (r_state == StRun);
    w_res_ready  = !w_empty && (r_state == StRun);
    w_push_fire  = bus.push_valid && w_push_ready;
    w_res_fire   = bus.res_valid && w_res_ready;
    w_head       = r_mem[r_rd_ptr];
    w_mispredict = w_res_fire && (w_head.taken != bus.res_taken);
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push_fire) begin
      r_mem[r_wr_ptr] <= '{taken: bus.push_taken, branch: bus.push_branch, src: bus.push_src};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state                 <= StRun;
      r_wr_ptr                <= '0;
      r_rd_ptr                <= '0;
      r_count                 <= '0;
      r_update_valid          <= 1'b0;
      r_update_taken          <= 1'b0;
      r_update_branch         <= '0;
      r_flush                 <= 1'b0;
      r_flush_branch          <= '0;
      r_resolved_cnt          <= '0;
      r_mispredict_cnt        <= '0;
      r_mispredict_global_cnt <= '0;
      r_id_error              <= 1'b0;
    end else begin
      r_update_valid <= w_res_fire;
      r_flush        <= w_mispredict;
      if (w_res_fire) begin
        r_update_taken  <= bus.res_taken;
        r_update_branch <= bus.res_branch;
        if (r_resolved_cnt != '1) r_resolved_cnt <= r_resolved_cnt + 1'b1;
        if (w_head.branch != bus.res_branch) r_id_error <= 1'b1;
      end
      if (w_mispredict) begin
        r_flush_branch <= w_head.branch;
        if (r_mispredict_cnt != '1) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
        if (!w_head.src && (r_mispredict_global_cnt != '1)) begin
          r_mispredict_global_cnt <= r_mispredict_global_cnt + 1'b1;
        end
      end

      case (r_state)
        StRun:   if (w_mispredict) r_state <= StFlush;
        StFlush: r_state <= StRun;
        default: r_state <= StRun;
      endcase

      // A mispredict drops every younger entry, including a same-cycle push.
      if (w_mispredict) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_res_fire)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_fire, w_res_fire})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.push_ready        = w_push_ready;
  assign bus.res_ready         = w_res_ready;
  assign bus.update_valid      = r_update_valid;
  assign bus.update_taken      = r_update_taken;
  assign bus.update_branch     = r_update_branch;
  assign bus.flush             = r_flush;
  assign bus.flush_branch      = r_flush_branch;
  assign o_count               = r_count;
  assign o_resolved_cnt        = r_resolved_cnt;
  assign o_mispredict_cnt      = r_mispredict_cnt;
  assign o_mispredict_global_cnt = r_mispredict_global_cnt;
  assign o_id_error            = r_id_error;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the predict/resolve rules.
module tb_branch_resolve_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ID_W  = 1;
  localparam int unsigned CNT_W = 5;  // narrow so the random phase reaches saturation
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int          CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    bit            taken;
    bit [ID_W-1:0] branch;
    bit            src;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [OCC_W-1:0] count;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] mispredict_cnt;
  logic [CNT_W-1:0] mispredict_global_cnt;
  logic             id_error;

  branch_resolve_queue_if #(.ID_W(ID_W)) bus_if ();

  branch_resolve_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .i_clk                   (clk),
    .i_reset                 (reset),
    .bus                     (bus_if),
    .o_count                 (count),
    .o_resolved_cnt          (resolved_cnt),
    .o_mispredict_cnt        (mispredict_cnt),
    .o_mispredict_global_cnt (mispredict_global_cnt),
    .o_id_error              (id_error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  ent_t          mq[$];
  bit            m_flushing;
  int            m_resolved, m_mis, m_gmis;
  bit            m_id_err;
  bit [ID_W-1:0] m_fb;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flushing = 1'b0;
    m_resolved = 0;
    m_mis      = 0;
    m_gmis     = 0;
    m_id_err   = 1'b0;
  endtask

  task automatic drive(input bit pv, input bit pt, input bit [ID_W-1:0] pb, input bit ps,
                       input bit rv, input bit rt, input bit [ID_W-1:0] rb);
    bus_if.push_valid  = pv;
    bus_if.push_taken  = pt;
    bus_if.push_branch = pb;
    bus_if.push_src    = ps;
    bus_if.res_valid   = rv;
    bus_if.res_taken   = rt;
    bus_if.res_branch  = rb;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit pv, input bit pt, input bit [ID_W-1:0] pb, input bit ps,
                      input bit rv, input bit rt, input bit [ID_W-1:0] rb);
    bit   epr, err, pf, rf, mis;
    ent_t h;
    drive(pv, pt, pb, ps, rv, rt, rb);
    epr = (mq.size() < DEPTH) && !m_flushing;
    err = (mq.size() > 0) && !m_flushing;
    #1;
    check_eq("push_ready", 32'(bus_if.push_ready), 32'(epr));
    check_eq("res_ready", 32'(bus_if.res_ready), 32'(err));
    pf  = pv && epr;
    rf  = rv && err;
    mis = 1'b0;
    if (rf) begin
      h = mq.pop_front();
      if (m_resolved < CMAX) m_resolved++;
      if (h.branch != rb) m_id_err = 1'b1;
      if (h.taken != rt) begin
        mis  = 1'b1;
        m_fb = h.branch;
        if (m_mis < CMAX) m_mis++;
        if (!h.src && m_gmis < CMAX) m_gmis++;
      end
    end
    if (pf && !mis) mq.push_back('{taken: pt, branch: pb, src: ps});
    if (mis) mq.delete();
    m_flushing = mis;
    @(posedge clk);
    #1;
    check_eq("update_valid", 32'(bus_if.update_valid), 32'(rf));
    if (rf) begin
      check_eq("update_taken", 32'(bus_if.update_taken), 32'(rt));
      check_eq("update_branch", 32'(bus_if.update_branch), 32'(rb));
    end
    check_eq("flush", 32'(bus_if.flush), 32'(mis));
    if (mis) check_eq("flush_branch", 32'(bus_if.flush_branch), 32'(m_fb));
    check_eq("count", 32'(count), mq.size());
    check_eq("resolved_cnt", 32'(resolved_cnt), m_resolved);
    check_eq("mispredict_cnt", 32'(mispredict_cnt), m_mis);
    check_eq("mispredict_global_cnt", 32'(mispredict_global_cnt), m_gmis);
    check_eq("id_error", 32'(id_error), 32'(m_id_err));
    @(negedge clk);
  endtask

  task automatic do_reset(input bit pv, input bit rv);
    reset = 1'b1;
    drive(pv, 1'($urandom), ID_W'($urandom), 1'($urandom), rv, 1'($urandom), ID_W'($urandom));
    @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_update_valid", 32'(bus_if.update_valid), 0);
    check_eq("rst_update_taken", 32'(bus_if.update_taken), 0);
    check_eq("rst_update_branch", 32'(bus_if.update_branch), 0);
    check_eq("rst_flush", 32'(bus_if.flush), 0);
    check_eq("rst_flush_branch", 32'(bus_if.flush_branch), 0);
    check_eq("rst_resolved_cnt", 32'(resolved_cnt), 0);
    check_eq("rst_mispredict_cnt", 32'(mispredict_cnt), 0);
    check_eq("rst_mispredict_global_cnt", 32'(mispredict_global_cnt), 0);
    check_eq("rst_id_error", 32'(id_error), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Resolve the model's head correctly (or pass rv=0 when empty), optionally with a push.
  task automatic step_good(input bit pv, input bit pt, input bit [ID_W-1:0] pb, input bit ps);
    if (mq.size() > 0) step(pv, pt, pb, ps, 1'b1, mq[0].taken, mq[0].branch);
    else               step(pv, pt, pb, ps, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, '0, 0, 0, 0, '0);
    model_reset();
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // Fill, then a fifth push is refused.
    for (int i = 0; i < DEPTH; i++) step(1, 1, ID_W'(i), 0, 0, 0, '0);
    step(1, 1, '0, 0, 0, 0, '0);
    // Drain with correct outcomes, then a resolve on empty is refused.
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 0, 1, 1, ID_W'(i));
    step(0, 0, '0, 0, 1, 1, '0);

    // Mispredict on the first of three global-source entries.
    for (int i = 0; i < 3; i++) step(1, 1, ID_W'(i), 0, 0, 0, '0);
    step(0, 0, '0, 0, 1, 0, '0);
    step(1, 1, '0, 0, 1, 1, '0);  // FLUSH cycle: nothing accepted
    step(0, 0, '0, 0, 0, 0, '0);

    // Full queue with push and resolve together, then wrap at count 2 with mixed directions.
    for (int i = 0; i < DEPTH; i++) step(1, 1, ID_W'(i), 1, 0, 0, '0);
    step_good(1, 1, '0, 1);
    step_good(0, 0, '0, 0);
    for (int i = 0; i < 7; i++) step_good(1, 1'($urandom), ID_W'($urandom), 1'($urandom));
    while (mq.size() > 0) step_good(0, 0, '0, 0);

    // Resolve ID mismatch is sticky through good traffic.
    step(1, 1, '0, 0, 0, 0, '0);
    step(0, 0, '0, 0, 1, 1, 1'b1);
    for (int i = 0; i < 6; i++) step_good(1, 1, ID_W'(i), 1);

    // Reset during the FLUSH cycle.
    while (mq.size() > 0) step_good(0, 0, '0, 0);
    step(1, 0, '0, 1, 0, 0, '0);
    step(0, 0, '0, 0, 1, 1, '0);
    do_reset(1'b1, 1'b1);
    step(1, 1, '1, 0, 0, 0, '0);

    // Random traffic; outcomes are mostly correct so the queue actually fills.
    for (int c = 0; c < 3000; c++) begin
      bit            rt;
      bit [ID_W-1:0] rb;
      if ($urandom_range(299) == 0) begin
        do_reset(1'($urandom), 1'($urandom));
      end else begin
        rt = 1'($urandom);
        rb = ID_W'($urandom);
        if (mq.size() > 0) begin
          rt = ($urandom_range(7) == 0) ? !mq[0].taken : mq[0].taken;
          rb = ($urandom_range(15) == 0) ? ~mq[0].branch : mq[0].branch;
        end
        step(($urandom_range(3) != 0), 1'($urandom), ID_W'($urandom), 1'($urandom),
             ($urandom_range(2) == 0), rt, rb);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
